receive: RTL and testbench
==========================

Name: receive

Overview:
- UART receiver; the serial-to-parallel counterpart of `transmit`. It sits directly downstream of a `transmit` instance in loopback, or on the external RX pin.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from `rxd` and presents each byte on a valid/ready style handshake to the consumer.
- Uses the same `BAUDRATE`/`FREQUENCY` parameterisation as `transmit`, so a matched pair interoperates by construction.

Parameters:
- BAUDRATE, 96e2, line bit rate in bits/s.
- FREQUENCY, 12e6, `clk` frequency in Hz.
- Derived, not overridable: CYCLES = $rtoi(FREQUENCY/BAUDRATE) = 1250 by default; HALF = CYCLES/2 = 625.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; synchronous, active-low (0 = reset, sampled on rising `clk`).
- rxd  input  1  serial line; idle high; asynchronous to `clk`.
- stb  output 1  byte valid.
- dat  output 8  received byte; valid while `stb`=1.
- rdy  input  1  consumer ready; a transfer occurs on a rising edge with `stb`=1 and `rdy`=1.

Behaviour:
- Reset:
  - `stb`=0, `dat`=8'h00.
  - FSM=IDLE; bit counter=0; baud counter=0.
  - Both synchroniser flops and the edge-detect flop reset to 1 (idle line).
- `rxd` passes through a 2-flop synchroniser (sync latency 2 cycles). All FSM decisions use the synchronised value `rxs`.
- Start detect: falling edge of `rxs` (previous=1, current=0). A line held low through reset release does not trigger; a falling edge is required.
- FSM states:
  - IDLE: on falling edge, load baud counter HALF-1, go to START.
  - START: decrement counter. At 0, sample `rxs`:
    - 0: load CYCLES-1, bit index=0, go to DATA.
    - 1: glitch; go to IDLE with no output.
  - DATA: at counter 0, shift[index]=`rxs` (LSB first) and reload CYCLES-1. After index 7, go to STOP; otherwise index++.
  - STOP: at counter 0, sample `rxs`:
    - 1 = valid frame: deliver (see output register), go to IDLE.
    - 0 = framing error: discard byte, go to BREAK.
  - BREAK: wait until `rxs`=1, then go to IDLE (re-arms only after the line returns high).
- Sampling is at mid-bit for every bit. Returning to IDLE at mid-stop allows back-to-back frames with exactly one stop bit.
- Latency: `stb` rises 9*CYCLES + HALF + 3 cycles (±1) after the `rxd` falling edge; 11878 with defaults.
- Output register:
  - Valid frame with `stb`=0: `dat`<=shift, `stb`<=1.
  - Valid frame with `stb`=1 and `rdy`=1 in the same cycle: `dat`<=new byte, `stb` stays 1. Not an overrun.
  - Valid frame with `stb`=1 and `rdy`=0: overrun. New byte dropped; `dat` keeps the old byte.
  - `stb`=1 and `rdy`=1 with no new frame: `stb`<=0 next cycle.
  - `dat` never changes while `stb`=1 && `rdy`=0.
  - `stb` is independent of `rdy` combinationally (no comb path from `rdy` to `stb` or `dat`).
- Reset mid-frame: abort immediately; FSM=IDLE, `stb`=0, no partial byte delivered. The remainder of the interrupted frame is ignored until its next falling edge. Any mis-detection is caught as a glitch or framing error.
- Counters: baud counter width $clog2(CYCLES); bit index 3 bits; no wrap beyond 7.

Optional Feature:
- Macro: RECEIVE_ERROR_EN.
- Defined: adds output `err` [1:0], reset 2'b00.
  - err[0] pulses for 1 cycle on a framing error (STOP sample 0).
  - err[1] pulses for 1 cycle on an overrun drop.
  - Both bits are 0 in every other cycle; they may assert in the same cycle only if both conditions occur in that cycle.
- Undefined: no `err` port; errors are silently discarded. All other behaviour is identical.

Test Plan:
- Frame 8'h55 at 9600 baud, `rdy`=1 -> `stb` high exactly 1 cycle at 11878±1 cycles after the start edge; `dat`=8'h55.
- Frame 8'hAA with `rdy`=0 held for 5000 cycles, then `rdy`=1 -> `stb`/`dat`=8'hAA held stable throughout; `stb` falls the cycle after `rdy` rises.
- `rxd` low pulse of 300 cycles (< HALF), then idle -> no `stb`. A following frame 8'h3C is received correctly.
- Frame 8'hF0 with stop bit 0, line high 2000 cycles later, then frame 8'h0F -> no `stb` for 8'hF0 (err[0] pulse when RECEIVE_ERROR_EN); `dat`=8'h0F delivered.
- `rdy`=0, two back-to-back frames 8'h12 then 8'h34 -> `dat` remains 8'h12 (err[1] pulse when enabled). Repeat with `rdy` pulsed in the second frame's delivery cycle -> `dat`=8'h34, no error.
- Loopback `transmit`.txd -> `rxd` for 8'h55, 8'hAA, 8'h00, 8'hFF -> all received in order. Assert `rst`=0 for 1 cycle mid-frame on the third byte -> no `stb` for that byte; the next frame is received correctly.

Source files
------------

// File: rtl/receive.sv
`timescale 1ns/1ps
// receive -- 8N1 UART receiver, the serial-to-parallel partner of transmit.
//
// Recovers frames of 1 start bit, 8 data bits (LSB first) and 1 stop bit from
// rxd. Every bit is sampled at mid-bit. Each byte is offered to the consumer
// on a valid/ready handshake.
//
// Parameters
//   BAUDRATE   line bit rate in bits/s
//   FREQUENCY  clk frequency in Hz
//   CYCLES = $rtoi(FREQUENCY/BAUDRATE) and HALF = CYCLES/2 are derived from
//   these two and cannot be overridden.
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous reset, active low
//   rxd   in   serial line, idle high, asynchronous to clk
//   stb   out  byte valid
//   dat   out  received byte, held while stb=1 and rdy=0
//   rdy   in   consumer ready; a byte transfers on a clock edge where stb=1 and rdy=1
//   err   out  only when RECEIVE_ERROR_EN is defined. Each bit is a one-cycle pulse:
//              err[0] = framing error, err[1] = overrun drop
//
// Optional feature macro: RECEIVE_ERROR_EN
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rxs
// START | counting half a bit, then checking that the start bit is still low
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit, then delivering the byte or flagging an error
// BREAK | framing error seen; waiting for the line to return high
module receive #(
    parameter real BAUDRATE  = 96e2,
    parameter real FREQUENCY = 12e6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       stb,
    output logic [7:0] dat,
`ifdef RECEIVE_ERROR_EN
    output logic [1:0] err,
`endif
    input  logic       rdy
);

    localparam int CYCLES = $rtoi(FREQUENCY / BAUDRATE);
    localparam int HALF   = CYCLES / 2;
    localparam int CW     = $clog2(CYCLES);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shift;
    logic            sync1;
    logic            rxs;
    logic            rxs_d;
    logic            falling;

    // The edge-detect flop resets high, so a line that is held low through
    // reset release does not count as a start bit.
    assign falling = rxs_d & ~rxs;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            stb   <= 1'b0;
            dat   <= '0;
`ifdef RECEIVE_ERROR_EN
            err   <= '0;
`endif
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            rxs_d <= rxs;
`ifdef RECEIVE_ERROR_EN
            err   <= '0;
`endif
            // Handshake completes. A delivery in STOP on the same edge
            // overrides this clear.
            if (stb && rdy)
                stb <= 1'b0;

            case (state)
                IDLE: begin
                    if (falling) begin
                        cnt   <= CW'(HALF - 1);
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (!rxs) begin
                        cnt   <= CW'(CYCLES - 1);
                        idx   <= '0;
                        state <= DATA;
                    end else
                        state <= IDLE;
                end
                DATA: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else begin
                        shift[idx] <= rxs;
                        cnt        <= CW'(CYCLES - 1);
                        if (idx == 3'd7)
                            state <= STOP;
                        else
                            idx <= idx + 3'd1;
                    end
                end
                STOP: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (rxs) begin
                        // Return to IDLE at mid-stop, so a following start
                        // bit right after a single stop bit is caught.
                        state <= IDLE;
                        if (!stb || rdy) begin
                            dat <= shift;
                            stb <= 1'b1;
                        end
`ifdef RECEIVE_ERROR_EN
                        else
                            err[1] <= 1'b1;
`endif
                    end else begin
                        state <= BREAK;
`ifdef RECEIVE_ERROR_EN
                        err[0] <= 1'b1;
`endif
                    end
                end
                BREAK: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_receive.sv
`timescale 1ns/1ps
module tb_receive;

    localparam real FREQ = 20e6;
    localparam real BAUD = 1e6;
    localparam int  C    = $rtoi(FREQ / BAUD);
    localparam int  H    = C / 2;
    localparam int  LAT  = 9 * C + H + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       stb;
    logic [7:0] dat;
    logic       rdy;
    logic       rdy_force = 1'b0;
    logic       rdy_rand  = 1'b0;
    bit         rand_rdy  = 1'b0;
`ifdef RECEIVE_ERROR_EN
    logic [1:0] err;
`endif

    assign rdy = rand_rdy ? rdy_rand : rdy_force;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = -1;
    int stb_hi   = 0;
    int err_fe   = 0;
    int err_or   = 0;
    int exp_fe   = 0;
    int exp_or   = 0;
    logic prev_stb = 1'b0;
    logic [7:0] q[$];

    receive #(.BAUDRATE(BAUD), .FREQUENCY(FREQ)) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .stb(stb),
        .dat(dat),
`ifdef RECEIVE_ERROR_EN
        .err(err),
`endif
        .rdy(rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = ($urandom % 3) != 0;
        end
    end

    // Monitor: while stb is high, dat must equal the oldest outstanding byte.
    // The byte is popped when the handshake completes.
    always @(negedge clk) begin
        if (stb === 1'b1) begin
            stb_hi++;
            if (!prev_stb) rise_cyc = cyc;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_stb dat=%h expected no output", dat);
            end else if (dat !== q[0]) begin
                failures++;
                $display("FAIL dat actual=%h expected=%h", dat, q[0]);
            end
            if (rdy && q.size() > 0) void'(q.pop_front());
        end
        prev_stb = (stb === 1'b1);
`ifdef RECEIVE_ERROR_EN
        if (err[0] === 1'b1) err_fe++;
        if (err[1] === 1'b1) err_or++;
`endif
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog timeout actual=%0d cycles expected completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame starting now. The line is left at the stop-bit value.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input bit expect_out, output int e0);
        if (expect_out) q.push_back(b);
        e0  = cyc;
        rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(C);
        end
        rxd = stop_v;
        tick(C);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            tick(1);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        int e0, e1, d, hi0, fe0, or0;
        logic [7:0] b;
        bit fe;

        // Reset state
        tick(3);
        check("reset_stb", int'(stb), 0);
        check("reset_dat", int'(dat), 0);
`ifdef RECEIVE_ERROR_EN
        check("reset_err", int'(err), 0);
`endif
        rst = 1'b1;
        tick(5);

        // 8'h55 with rdy=1: exact latency and a one-cycle stb
        rdy_force = 1'b1;
        hi0 = stb_hi;
        rise_cyc = -1;
        send_frame(8'h55, 1'b1, 1'b1, e0);
        tick(2);
        d = rise_cyc - e0;
        checks++;
        if (d < LAT - 1 || d > LAT + 1) begin
            failures++;
            $display("FAIL latency actual=%0d expected=%0d+-1", d, LAT);
        end
        check("stb_one_cycle", stb_hi - hi0, 1);
        check("q_55", q.size(), 0);

        // 8'hAA with rdy=0 held, then rdy=1
        rdy_force = 1'b0;
        send_frame(8'hAA, 1'b1, 1'b1, e0);
        tick(10 * C);
        check("hold_stb", int'(stb), 1);
        check("hold_dat", int'(dat), 8'hAA);
        rdy_force = 1'b1;
        tick(1);
        check("stb_fall", int'(stb), 0);
        check("q_aa", q.size(), 0);

        // Short low glitch, then a valid frame
        hi0 = stb_hi;
        rxd = 1'b0;
        tick(H - 3);
        rxd = 1'b1;
        tick(3 * C);
        check("glitch_no_stb", stb_hi - hi0, 0);
        send_frame(8'h3C, 1'b1, 1'b1, e0);
        tick(C);
        check("q_3c", q.size(), 0);

        // Framing error on 8'hF0, line returns high later, then 8'h0F
        hi0 = stb_hi;
        fe0 = err_fe;
        send_frame(8'hF0, 1'b0, 1'b0, e0);
        exp_fe++;
        tick(2 * C);
        rxd = 1'b1;
        tick(5 * C);
`ifdef RECEIVE_ERROR_EN
        check("err_fe_pulse", err_fe - fe0, 1);
`endif
        send_frame(8'h0F, 1'b1, 1'b1, e0);
        tick(C);
        check("q_0f", q.size(), 0);
        check("fe_one_delivery", stb_hi - hi0, 1);

        // Overrun: 8'h12 then 8'h34 back to back with rdy=0
        rdy_force = 1'b0;
        or0 = err_or;
        send_frame(8'h12, 1'b1, 1'b1, e0);
        send_frame(8'h34, 1'b1, 1'b0, e1);
        exp_or++;
        tick(C);
        check("overrun_stb", int'(stb), 1);
        check("overrun_dat", int'(dat), 8'h12);
`ifdef RECEIVE_ERROR_EN
        check("err_or_pulse", err_or - or0, 1);
`endif
        rdy_force = 1'b1;
        tick(2);
        check("q_overrun", q.size(), 0);

        // Same pair, with rdy pulsed on the second delivery edge
        rdy_force = 1'b0;
        or0 = err_or;
        send_frame(8'h12, 1'b1, 1'b1, e0);
        fork
            send_frame(8'h34, 1'b1, 1'b1, e1);
            begin
                tick(LAT - 1);
                rdy_force = 1'b1;
                tick(1);
                rdy_force = 1'b0;
            end
        join
        tick(C);
        check("swap_dat", int'(dat), 8'h34);
        check("swap_stb", int'(stb), 1);
        check("swap_no_overrun", err_or - or0, 0);
        rdy_force = 1'b1;
        tick(2);
        check("q_swap", q.size(), 0);

        // Loopback-style sequence with a reset late in the third byte
        send_frame(8'h55, 1'b1, 1'b1, e0);
        send_frame(8'hAA, 1'b1, 1'b1, e0);
        fork
            send_frame(8'h00, 1'b1, 1'b0, e0);
            begin
                tick(8 * C + (3 * C) / 4);
                rst = 1'b0;
                tick(1);
                rst = 1'b1;
                check("rst_stb", int'(stb), 0);
            end
        join
        send_frame(8'hFF, 1'b1, 1'b1, e0);
        tick(C);
        check("q_loop", q.size(), 0);

        // Randomized frames with random rdy and occasional framing errors
        rand_rdy = 1'b1;
        for (int k = 0; k < 25; k++) begin
            b  = 8'($urandom);
            fe = ($urandom % 5) == 0;
            send_frame(b, !fe, !fe, e0);
            if (fe) begin
                exp_fe++;
                tick(C);
                rxd = 1'b1;
            end else begin
                drain(400);
            end
            tick(4 + $urandom_range(0, 2 * C));
        end
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        tick(10);
        check("final_q_empty", q.size(), 0);
`ifdef RECEIVE_ERROR_EN
        check("err_fe_total", err_fe, exp_fe);
        check("err_or_total", err_or, exp_or);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
